// File: rtl/snake_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : snake_game_ctrl
// Description : Game sequencer for the VGA snake datapath. It turns frame
//               boundaries into single-cycle step strobes, buffers button
//               direction requests in a 2-entry queue and runs the
//               IDLE/RUN/PAUSED/DEAD game state machine.
// Ports       : clk50            - system clock
//               reset            - asynchronous active-high reset
//               vert_sync        - active-low vertical sync (synchronized here)
//               k0..k3           - active-low buttons: up, right, down, left
//               pause            - level pause request
//               collision        - 1-cycle pulse, head hit wall/body
//               food_eaten       - 1-cycle pulse, food consumed
//               step             - 1-cycle snake advance strobe
//               dir              - heading: 00 up, 01 right, 10 down, 11 left
//               game_state       - 00 IDLE, 01 RUN, 10 PAUSED, 11 DEAD
//               game_over        - high in DEAD
//               frames_per_step  - current step period in frames
// Revision    : 1.0 - initial release
// ============================================================================
module snake_game_ctrl #(
    parameter int FRAMES_PER_STEP_INIT = 8,
    parameter int FRAMES_PER_STEP_MIN  = 2,
    parameter int SPEEDUP_EVERY        = 4
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       vert_sync,
    input  logic       k0,
    input  logic       k1,
    input  logic       k2,
    input  logic       k3,
    input  logic       pause,
    input  logic       collision,
    input  logic       food_eaten,
    output logic       step,
    output logic [1:0] dir,
    output logic [1:0] game_state,
    output logic       game_over,
    output logic [3:0] frames_per_step
);

    localparam logic [3:0] c_fps_init   = 4'(FRAMES_PER_STEP_INIT);
    localparam logic [3:0] c_fps_min    = 4'(FRAMES_PER_STEP_MIN);
    localparam logic [3:0] c_food_limit = 4'(SPEEDUP_EVERY - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_DEAD   = 2'b11
    } state_t;

    // ---------------- input conditioning ----------------
    logic [1:0] r_vs_sync;
    logic       r_vs_prev;
    logic [3:0] r_key_s1, r_key_s2, r_key_prev;
    logic [1:0] r_pause_sync;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_vs_sync    <= 2'b11;
            r_vs_prev    <= 1'b1;
            r_key_s1     <= 4'hF;
            r_key_s2     <= 4'hF;
            r_key_prev   <= 4'hF;
            r_pause_sync <= 2'b00;
        end else begin
            r_vs_sync    <= {r_vs_sync[0], vert_sync};
            r_vs_prev    <= r_vs_sync[1];
            r_key_s1     <= {k3, k2, k1, k0};
            r_key_s2     <= r_key_s1;
            r_key_prev   <= r_key_s2;
            r_pause_sync <= {r_pause_sync[0], pause};
        end
    end

    logic       w_frame_edge;
    logic [3:0] w_press;
    logic       w_pause;
    logic       w_key_valid;
    logic [1:0] w_key_dir;

    assign w_frame_edge = r_vs_sync[1] & ~r_vs_prev;
    assign w_press      = r_key_prev & ~r_key_s2;
    assign w_pause      = r_pause_sync[1];

    // Button index equals its direction code; lowest index wins.
    always_comb begin
        w_key_valid = 1'b1;
        w_key_dir   = 2'd0;
        if      (w_press[0]) w_key_dir = 2'd0;
        else if (w_press[1]) w_key_dir = 2'd1;
        else if (w_press[2]) w_key_dir = 2'd2;
        else if (w_press[3]) w_key_dir = 2'd3;
        else                 w_key_valid = 1'b0;
    end

    // ---------------- game state ----------------
    state_t     r_state, w_state_nxt;
    logic       r_step, w_step_nxt;
    logic [1:0] r_dir, w_dir_nxt;
    logic       r_game_over, w_game_over_nxt;
    logic [3:0] r_fps, w_fps_nxt;
    logic [3:0] r_frame_cnt, w_frame_cnt_nxt;
    logic [3:0] r_food_cnt, w_food_cnt_nxt;
    logic [1:0] r_q0, r_q1, w_q0_nxt, w_q1_nxt;   // q0 is the head
    logic [1:0] r_q_cnt, w_q_cnt_nxt;

    logic       w_keys_open;
    logic       w_pop;
    logic [1:0] w_q0_p;
    logic [1:0] w_q_cnt_p;
    logic [1:0] w_ref;
    logic       w_accept;

    always_comb begin
        w_state_nxt     = r_state;
        w_step_nxt      = 1'b0;
        w_frame_cnt_nxt = r_frame_cnt;
        w_food_cnt_nxt  = r_food_cnt;
        w_fps_nxt       = r_fps;
        w_keys_open     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Any press starts the game; it is queued only if it passes
                // the same heading filter used while running.
                w_keys_open = 1'b1;
                if (w_key_valid) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (collision) begin
                    w_state_nxt = ST_DEAD;
                end else begin
                    if (food_eaten && (r_fps > c_fps_min)) begin
                        if (r_food_cnt >= c_food_limit) begin
                            w_food_cnt_nxt = 4'd0;
                            w_fps_nxt      = r_fps - 4'd1;
                        end else begin
                            w_food_cnt_nxt = r_food_cnt + 4'd1;
                        end
                    end
                    if (w_pause) begin
                        w_state_nxt = ST_PAUSED;
                    end else begin
                        w_keys_open = 1'b1;
                        if (w_frame_edge) begin
                            // >= keeps a speedup that lands mid-count from
                            // skipping past the terminal value.
                            if (r_frame_cnt >= r_fps - 4'd1) begin
                                w_step_nxt      = 1'b1;
                                w_frame_cnt_nxt = 4'd0;
                            end else begin
                                w_frame_cnt_nxt = r_frame_cnt + 4'd1;
                            end
                        end
                    end
                end
            end
            ST_PAUSED: begin
                if (!w_pause) w_state_nxt = ST_RUN;
            end
            default: ;  // DEAD: only reset leaves
        endcase

        // Pop happens before the new key is compared, so a full queue that
        // pops this cycle still has room for the press.
        w_pop     = w_step_nxt && (r_q_cnt != 2'd0);
        w_q0_p    = w_pop ? r_q1 : r_q0;
        w_q_cnt_p = r_q_cnt - {1'b0, w_pop};
        w_dir_nxt = w_pop ? r_q0 : r_dir;

        case (w_q_cnt_p)
            2'd0:    w_ref = w_dir_nxt;
            2'd1:    w_ref = w_q0_p;
            default: w_ref = r_q1;
        endcase

        w_accept = w_keys_open && w_key_valid && (w_q_cnt_p != 2'd2) &&
                   (w_key_dir != w_ref) && (w_key_dir != (w_ref ^ 2'b10));

        w_q0_nxt    = w_q0_p;
        w_q1_nxt    = r_q1;
        w_q_cnt_nxt = w_q_cnt_p;
        if (w_accept) begin
            if (w_q_cnt_p == 2'd0) w_q0_nxt = w_key_dir;
            else                   w_q1_nxt = w_key_dir;
            w_q_cnt_nxt = w_q_cnt_p + 2'd1;
        end

        w_game_over_nxt = (w_state_nxt == ST_DEAD);
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_step      <= 1'b0;
            r_dir       <= 2'b01;
            r_game_over <= 1'b0;
            r_fps       <= c_fps_init;
            r_frame_cnt <= 4'd0;
            r_food_cnt  <= 4'd0;
            r_q0        <= 2'd0;
            r_q1        <= 2'd0;
            r_q_cnt     <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_step      <= w_step_nxt;
            r_dir       <= w_dir_nxt;
            r_game_over <= w_game_over_nxt;
            r_fps       <= w_fps_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_food_cnt  <= w_food_cnt_nxt;
            r_q0        <= w_q0_nxt;
            r_q1        <= w_q1_nxt;
            r_q_cnt     <= w_q_cnt_nxt;
        end
    end

    assign step            = r_step;
    assign dir             = r_dir;
    assign game_state      = r_state;
    assign game_over       = r_game_over;
    assign frames_per_step = r_fps;

endmodule
`default_nettype wire
